// File: rtl/encoder_period_meter_1_if.sv
// rtl/encoder_period_meter_1_if.sv - encoder pin inputs and speed/position outputs
interface encoder_period_meter_1_if #(
  parameter int PERIOD_W = 16
);
  logic                encoder_a;
  logic                encoder_b;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                stalled;
  logic                direction;
  logic [PERIOD_W-1:0] position;
  logic                quad_err;

  modport master (
    output encoder_a, encoder_b,
    input  period, period_valid, stalled, direction, position, quad_err
  );

  modport slave (
    input  encoder_a, encoder_b,
    output period, period_valid, stalled, direction, position, quad_err
  );
endinterface

// File: rtl/encoder_period_meter_1.sv
// rtl/encoder_period_meter_1.sv - quadrature decoder with channel-A period meter
module encoder_period_meter_1 #(
  parameter int PERIOD_W = 16,
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  encoder_period_meter_1_if.slave bus
);
  localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;
  localparam logic [PERIOD_W-1:0] CNT_ONE  = 1;
  localparam logic [3:0]          FILT_TGT = 4'(FILT_LEN);

  logic                a_m, a_s, b_m, b_s;
  logic                a_f, b_f, a_fd, b_fd;
  logic [3:0]          a_fc, b_fc;
  logic [PERIOD_W-1:0] cnt, period_q, position_q;
  logic                armed, pv_q, stalled_q, dir_q, err_q;
  logic [1:0]          q_prev, q_cur, q_fwd;
  logic                step_fwd, step_rev, step_bad, a_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_m  <= 1'b0; a_s  <= 1'b0; b_m <= 1'b0; b_s <= 1'b0;
      a_f  <= 1'b0; b_f  <= 1'b0; a_fd <= 1'b0; b_fd <= 1'b0;
      a_fc <= 4'd0; b_fc <= 4'd0;
    end else begin
      a_m  <= bus.encoder_a;
      a_s  <= a_m;
      b_m  <= bus.encoder_b;
      b_s  <= b_m;
      a_fd <= a_f;
      b_fd <= b_f;
      if (a_s == a_f) begin
        a_fc <= 4'd0;
      end else if (a_fc + 4'd1 == FILT_TGT) begin
        a_f  <= a_s;
        a_fc <= 4'd0;
      end else begin
        a_fc <= a_fc + 4'd1;
      end
      if (b_s == b_f) begin
        b_fc <= 4'd0;
      end else if (b_fc + 4'd1 == FILT_TGT) begin
        b_f  <= b_s;
        b_fc <= 4'd0;
      end else begin
        b_fc <= b_fc + 4'd1;
      end
    end
  end

  // Forward successor of {a,b} in the ring 00->10->11->01 is {~b, a}.
  always_comb begin
    q_prev   = {a_fd, b_fd};
    q_cur    = {a_f, b_f};
    q_fwd    = {~q_prev[0], q_prev[1]};
    step_bad = (q_prev[1] ^ q_cur[1]) & (q_prev[0] ^ q_cur[0]);
    step_fwd = 1'b0;
    step_rev = 1'b0;
    if (q_cur != q_prev && !step_bad) begin
      if (q_cur == q_fwd) step_fwd = 1'b1;
      else                step_rev = 1'b1;
    end
    a_rise = a_f & ~a_fd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      position_q <= '0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (step_fwd) begin
        position_q <= position_q + CNT_ONE;
        dir_q      <= 1'b1;
      end else if (step_rev) begin
        position_q <= position_q - CNT_ONE;
        dir_q      <= 1'b0;
      end
      if (step_bad) err_q <= 1'b1;
    end
  end

  // An edge coinciding with cnt==MAX wins over the stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      period_q  <= '0;
      pv_q      <= 1'b0;
      stalled_q <= 1'b1;
      armed     <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      if (a_rise) begin
        cnt <= CNT_ONE;
        if (armed) begin
          period_q <= cnt;
          pv_q     <= 1'b1;
        end else begin
          armed     <= 1'b1;
          stalled_q <= 1'b0;
        end
      end else if (cnt == CNT_MAX) begin
        if (armed) begin
          period_q  <= CNT_MAX;
          pv_q      <= 1'b1;
          stalled_q <= 1'b1;
          armed     <= 1'b0;
        end
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.stalled      = stalled_q;
  assign bus.direction    = dir_q;
  assign bus.position     = position_q;
  assign bus.quad_err     = err_q;
endmodule

// File: tb/tb_encoder_period_meter_1.sv
// tb/tb_encoder_period_meter_1.sv - scoreboard bench for encoder_period_meter_1
module tb_encoder_period_meter_1;
  localparam int PW   = 8;
  localparam int FL   = 4;
  localparam int MAXV = (1 << PW) - 1;
  localparam int LAT  = FL + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  encoder_period_meter_1_if #(.PERIOD_W(PW)) bus();

  encoder_period_meter_1 #(.PERIOD_W(PW), .FILT_LEN(FL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int per;
    bit stl;
    int due;
  } exp_t;
  exp_t q[$];

  // Reference model: pin-level events, timed in bench cycles.
  int          m_last;
  bit          m_armed;
  bit [1:0]    m_ab;
  logic [PW-1:0] m_pos;
  bit          m_dir;
  bit          m_err;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int ring(input bit [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_last  = 0;
    m_armed = 0;
    m_ab    = 2'b00;
    m_pos   = '0;
    m_dir   = 0;
    m_err   = 0;
    q.delete();
  endtask

  task automatic model_change(input bit [1:0] ab, input int n);
    int d;
    exp_t e;
    d = (ring(ab) - ring(m_ab) + 4) % 4;
    if (d == 1) begin m_pos = m_pos + 1'b1; m_dir = 1; end
    else if (d == 3) begin m_pos = m_pos - 1'b1; m_dir = 0; end
    else if (d == 2) m_err = 1;
    if (ab[1] && !m_ab[1]) begin
      if (m_armed) begin
        e.per = n - m_last; e.stl = 0; e.due = n + LAT;
        q.push_back(e);
      end
      m_armed = 1;
      m_last  = n;
    end
    m_ab = ab;
  endtask

  // Pins are quiet from n to n+len: predict a stall if the gap exceeds MAX.
  task automatic model_hold(input int n, input int len);
    exp_t e;
    if (m_armed && (n + len - m_last) > MAXV) begin
      e.per = MAXV; e.stl = 1; e.due = m_last + LAT + MAXV;
      q.push_back(e);
      m_armed = 0;
    end
  endtask

  task automatic drive(input bit a, input bit b, input int hold);
    int n;
    bus.encoder_a = a;
    bus.encoder_b = b;
    n = cyc;
    model_change({a, b}, n);
    model_hold(n, hold);
    repeat (hold) @(negedge clk);
    if (hold >= LAT + 1) begin
      check("position", int'(bus.position), int'(m_pos));
      check("direction", int'(bus.direction), int'(m_dir));
      check("quad_err", int'(bus.quad_err), int'(m_err));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.period_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: period=%0d with no expected pulse (cycle %0d)", bus.period, cyc);
      end else begin
        e = q.pop_front();
        check("period", int'(bus.period), e.per);
        check("pulse_cycle", cyc, e.due);
        check("stalled_at_pulse", int'(bus.stalled), int'(e.stl));
      end
    end
  end

  initial begin
    bit [1:0] ab;
    int       hold;
    rst = 1'b1;
    bus.encoder_a = 1'b0;
    bus.encoder_b = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_period", int'(bus.period), 0);
    check("rst_pv", int'(bus.period_valid), 0);
    check("rst_stalled", int'(bus.stalled), 1);
    check("rst_direction", int'(bus.direction), 0);
    check("rst_position", int'(bus.position), 0);
    check("rst_quad_err", int'(bus.quad_err), 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_stalled", int'(bus.stalled), 1);
    end

    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 40);
      if (i == 0) check("first_rise_unstalls", int'(bus.stalled), 0);
      drive(1, 1, 40);
      drive(0, 1, 40);
      drive(0, 0, 40);
    end
    check("fwd_position", int'(bus.position), 12);

    do_reset();
    check("midrst_position", int'(bus.position), 0);
    check("midrst_stalled", int'(bus.stalled), 1);

    drive(0, 1, 40);
    check("rev_wrap", int'(bus.position), MAXV);
    check("rev_dir", int'(bus.direction), 0);
    drive(1, 1, 40);
    drive(1, 0, 40);
    drive(0, 0, 40);
    drive(0, 1, 40);
    drive(1, 1, 40);
    drive(1, 0, 40);
    drive(0, 0, 40);

    model_hold(cyc, 23);
    bus.encoder_a = 1'b1;
    repeat (3) @(negedge clk);
    bus.encoder_a = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_position", int'(bus.position), int'(m_pos));
    check("glitch_err", int'(bus.quad_err), 0);
    drive(1, 0, 4);
    drive(0, 0, 20);
    check("pulse4_position", int'(bus.position), int'(m_pos));

    drive(1, 1, 40);
    check("illegal_err", int'(bus.quad_err), 1);
    drive(0, 1, 40);
    drive(0, 0, 40);
    check("err_sticky", int'(bus.quad_err), 1);

    drive(0, 0, 300);
    check("stall_level", int'(bus.stalled), 1);
    drive(1, 0, 25);
    check("rearm_unstalls", int'(bus.stalled), 0);
    drive(0, 0, 25);
    drive(1, 0, 25);
    drive(0, 0, 230);
    drive(1, 0, 40);
    check("max_gap_no_stall", int'(bus.stalled), 0);

    for (int i = 0; i < 40; i++) begin
      ab   = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 9) == 0) ? 300 : int'($urandom_range(8, 90));
      drive(ab[1], ab[0], hold);
    end
    drive(0, 0, 300);
    repeat (20) @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/encoder_period_meter_1.md
# encoder_period_meter_1

Quadrature encoder front end that sits between the motor encoder pins and the PID stage inside `bldc_esc_1`. It synchronises and de-glitches `encoder_a`/`encoder_b` and decodes direction and position. It also measures the clock-cycle period between successive rising edges of filtered channel A. The resulting `period` is the measured speed term that the PID compares against the I2C-programmed `period_reference`.

## Interface
- `PERIOD_W`, 16: width of period counter, `period` and `position`.
- `FILT_LEN`, 4: consecutive stable cycles required before the filter accepts a new input level. Legal range is 1..15.
- `clk`  in  1  system clock. The block has one clock.
- `rst`  in  1  reset, synchronous and active-high.
- `encoder_a`  in  1  raw encoder channel A, asynchronous to `clk`.
- `encoder_b`  in  1  raw encoder channel B, asynchronous to `clk`.
- `period`  out  PERIOD_W  last measured A-rise-to-A-rise period, in clk cycles.
- `period_valid`  out  1  one-cycle pulse when `period` is updated.
- `stalled`  out  1  high when no A rising edge has been seen for 2^PERIOD_W−1 cycles, or since reset.
- `direction`  out  1  direction of the last legal quadrature step. 1 = forward (A leads B).
- `position`  out  PERIOD_W  wrapping two's-complement step count.
- `quad_err`  out  1  sticky flag: an illegal quadrature transition occurred. Cleared only by `rst`.

## Operation
- **Synchroniser:** each channel passes through a 2-FF synchroniser (`a_s`, `b_s`).
- **Filter:** one filter per channel. Each holds a filtered level (`a_f`, `b_f`) and a 4-bit stability counter.
  - Counter clears whenever the synced level equals the filtered level.
  - Otherwise the counter increments; when it reaches FILT_LEN, the filtered level takes the synced level and the counter clears.
- **Quadrature decode:** compare {a_f, b_f} against its previous-cycle copy.
  - Forward sequence is 00→10→11→01→00: `position`+1 and `direction`=1.
  - Reverse sequence is the opposite: `position`−1 and `direction`=0.
  - Both bits changing in one cycle: `quad_err`←1; `position` and `direction` are unchanged.
  - No change: nothing.
  - `position` wraps modulo 2^PERIOD_W.
- **Period counter `cnt`:** PERIOD_W bits, increments every cycle, saturates at MAX = 2^PERIOD_W−1.
- **A rising edge** (a_f=1 and its previous value=0):
  - If `armed`: `period`←`cnt`, `period_valid`←1, `cnt`←1.
  - If not `armed` (first edge after reset or after a stall): `armed`←1, `stalled`←0, `cnt`←1, no `period_valid`.
- **Stall:** when `cnt`==MAX, `armed`=1 and there is no edge in that cycle:
  - `period`←MAX, `period_valid`←1 for exactly one cycle, `stalled`←1, `armed`←0.
  - `cnt` then holds at MAX with no further pulses until the next edge.
- **Simultaneous events:** an edge in the same cycle that `cnt`==MAX is treated as an edge. The block publishes `period`=MAX as a normal measurement and `stalled` stays 0.
- **Period definition:** for edges exactly N cycles apart, `period`=N.
- **Reset values:**
  - Outputs: `period`=0, `period_valid`=0, `stalled`=1, `direction`=0, `position`=0, `quad_err`=0.
  - Internal: `cnt`=0, `armed`=0, synchronisers, filtered levels and filter counters all 0.
- **Non-zero pin levels at reset:** seen as transitions after reset. They may step `position`, and they only arm the period logic, never publish.
- **Reset mid-operation:** everything returns to reset values in the same cycle. A measurement in progress is discarded.

## Timing
- Synchroniser: a pin change first sampled on clk edge k appears on `a_s` at edge k+1.
- Filtered level changes at edge k+1+FILT_LEN.
- `period_valid`, `position` and `direction` update at edge k+2+FILT_LEN. All outputs are registered.
- A pin pulse shorter than FILT_LEN cycles after synchronisation never reaches `a_f`/`b_f`.
- `period_valid` is never high on two consecutive cycles: minimum filtered edge spacing is 2×FILT_LEN.
- `period` holds its value between pulses. `stalled` and `direction` are level outputs.

## Test plan
- **Reset:** assert `rst` 2 cycles with pins at 0 → all outputs at reset values; `stalled`=1 and `period_valid`=0 for 100 cycles.
- **Forward rotation:** A/B forward quadrature with 40 cycles per state (160-cycle A period), FILT_LEN=4.
  - First A rise: no pulse, `stalled`→0.
  - Each later A rise: `period`=160 with `period_valid` pulse, `direction`=1, `position` +4 per A cycle.
  - Pulse occurs exactly 6 cycles after the pin edge.
- **Reverse and wrap:** reverse sequence from `position`=0 → `position`=0xFFFF after the first step, `direction`=0; `period` still measured correctly.
- **Glitch rejection:** 3-cycle high pulse on A with FILT_LEN=4 → no change to `position`, `period` or `quad_err`. A 4-cycle pulse is accepted.
- **Illegal step:** drive A and B low→high in the same cycle → `quad_err`=1 and stays 1; `position` unchanged.
- **Stall with PERIOD_W=8:**
  - Stop the encoder after arming → after 255 cycles, one `period_valid` with `period`=255 and `stalled`=1; no further pulses.
  - Next A rise: `stalled`=0, no pulse.
  - Following rise 50 cycles later: `period`=50.
